// File: rtl/rfe_sweep_ctrl_pkg.sv
// Shared definitions for the RF front-end sweep sequencer: register offsets,
// CTRL bit positions, FSM encoding and the status readback layout.
package rfe_sweep_ctrl_pkg;

   localparam logic [6:0] FR_RFE_SWEEP_CTRL    = 7'd0;
   localparam logic [6:0] FR_RFE_SWEEP_SETTLE  = 7'd1;
   localparam logic [6:0] FR_RFE_SWEEP_SAMPLES = 7'd2;
   localparam logic [6:0] FR_RFE_SWEEP_TABLE   = 7'd3;

   localparam int CTRL_START_BIT   = 0;
   localparam int CTRL_ABORT_BIT   = 1;
   localparam int CTRL_LOOP_BIT    = 2;
   localparam int CTRL_LAST_LSB    = 4;
   localparam int CTRL_CLR_OVR_BIT = 8;
   localparam int TBL_IDX_LSB      = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_DWELL  = 3'd3,
      ST_NEXT   = 3'd4
   } sweep_state_t;

   function automatic logic [31:0] pack_status(input logic         ovr,
                                               input sweep_state_t st,
                                               input logic [7:0]   step,
                                               input logic [7:0]   dwell);
      return {ovr, 12'b0, st, step, dwell};
   endfunction

endpackage

// File: rtl/rfe_sweep_ctrl_if.sv
// Serial register write bus (serial_strobe / serial_addr / serial_data) as seen
// by the sweep sequencer; the host side drives it, the sequencer listens.
interface rfe_sweep_ctrl_if;

   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        serial_strobe;

   modport master (
      output serial_addr,
      output serial_data,
      output serial_strobe
   );

   modport slave (
      input serial_addr,
      input serial_data,
      input serial_strobe
   );

endinterface

// File: rtl/rfe_sweep_ctrl_table.sv
// Front-end word table: DEPTH x 6 distributed RAM, synchronous write and
// asynchronous read, so a same-cycle write/read of one entry returns the old word.
module rfe_sweep_ctrl_table #(
   parameter  int DEPTH = 8,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [5:0]    wdata,
   input  logic [IW-1:0] raddr,
   output logic [5:0]    rdata
);

   logic [5:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/rfe_sweep_ctrl.sv
// RF front-end sweep sequencer: applies each table word, waits SETTLE cycles,
// then gates rx capture for SAMPLES hb_strobes before moving to the next entry.
module rfe_sweep_ctrl
   import rfe_sweep_ctrl_pkg::*;
#(
   parameter  logic [6:0] BASE_ADDR = 7'd72,
   parameter  int         DEPTH     = 8,
   localparam int         IW        = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            reset,
   rfe_sweep_ctrl_if.slave sbus,
   input  logic            hb_strobe,
   input  logic            rx_overrun,
   output logic [5:0]      rfe_ctrl,
   output logic            capture_en,
   output logic            busy,
   output logic [IW-1:0]   step_index,
   output logic            sweep_done,
   output logic [31:0]     status
);

   logic [31:0] sdata;
   logic        wr_ctrl, wr_settle, wr_samples, wr_table;
   logic        start_wr, abort_wr, clr_ovr;
   logic        unused_sdata;

   sweep_state_t  state_q, state_d;
   logic [15:0]   settle_q, settle_d;
   logic [15:0]   samples_q, samples_d;
   logic          loop_q, loop_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] step_index_q, step_index_d;
   logic [5:0]    rfe_ctrl_q, rfe_ctrl_d;
   logic          capture_en_q, capture_en_d;
   logic          sweep_done_q, sweep_done_d;
   logic [15:0]   settle_cnt_q, settle_cnt_d;
   logic [15:0]   dwell_cnt_q, dwell_cnt_d;
   logic          ovr_sticky_q, ovr_sticky_d;
   logic [5:0]    tbl_word;
   sweep_state_t  after_settle;
   logic          last_hb;

   assign sdata      = sbus.serial_data;
   assign wr_ctrl    = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + FR_RFE_SWEEP_CTRL);
   assign wr_settle  = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + FR_RFE_SWEEP_SETTLE);
   assign wr_samples = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + FR_RFE_SWEEP_SAMPLES);
   assign wr_table   = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + FR_RFE_SWEEP_TABLE);

   assign start_wr = wr_ctrl && sdata[CTRL_START_BIT];
   assign abort_wr = wr_ctrl && sdata[CTRL_ABORT_BIT];
   assign clr_ovr  = wr_ctrl && sdata[CTRL_CLR_OVR_BIT];

   assign unused_sdata = ^sdata[31:IW+16];

   rfe_sweep_ctrl_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .clock (clock),
      .we    (wr_table),
      .waddr (sdata[TBL_IDX_LSB +: IW]),
      .wdata (sdata[5:0]),
      .raddr (step_index_q),
      .rdata (tbl_word)
   );

   // Configuration is live: a mid-sweep write is picked up at its next use.
   always_comb begin
      settle_d  = settle_q;
      samples_d = samples_q;
      loop_d    = loop_q;
      last_d    = last_q;
      if (wr_settle) begin
         settle_d = sdata[15:0];
      end
      if (wr_samples) begin
         samples_d = sdata[15:0];
      end
      if (wr_ctrl) begin
         loop_d = sdata[CTRL_LOOP_BIT];
         last_d = sdata[CTRL_LAST_LSB +: IW];
      end
      ovr_sticky_d = (ovr_sticky_q && !clr_ovr) || (rx_overrun && capture_en);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         settle_q     <= '0;
         samples_q    <= '0;
         loop_q       <= 1'b0;
         last_q       <= '0;
         step_index_q <= '0;
         rfe_ctrl_q   <= '0;
         capture_en_q <= 1'b0;
         sweep_done_q <= 1'b0;
         settle_cnt_q <= '0;
         dwell_cnt_q  <= '0;
         ovr_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_q     <= settle_d;
         samples_q    <= samples_d;
         loop_q       <= loop_d;
         last_q       <= last_d;
         step_index_q <= step_index_d;
         rfe_ctrl_q   <= rfe_ctrl_d;
         capture_en_q <= capture_en_d;
         sweep_done_q <= sweep_done_d;
         settle_cnt_q <= settle_cnt_d;
         dwell_cnt_q  <= dwell_cnt_d;
         ovr_sticky_q <= ovr_sticky_d;
      end
   end

   assign after_settle = (samples_q == 16'd0) ? ST_NEXT : ST_DWELL;
   assign last_hb      = hb_strobe && ((dwell_cnt_q + 16'd1) == samples_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_wr) begin
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            state_d = (settle_q == 16'd0) ? after_settle : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt_q <= 16'd1) begin
               state_d = after_settle;
            end
         end
         ST_DWELL: begin
            if (last_hb) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            state_d = (step_index_q == last_q && !loop_q) ? ST_IDLE : ST_APPLY;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides everything, including a start in the same cycle.
      if (abort_wr) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      rfe_ctrl_d   = rfe_ctrl_q;
      step_index_d = step_index_q;
      settle_cnt_d = settle_cnt_q;
      dwell_cnt_d  = dwell_cnt_q;
      sweep_done_d = 1'b0;
      capture_en_d = (state_d == ST_DWELL);
      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_APPLY) begin
               step_index_d = '0;
            end
         end
         ST_APPLY: begin
            if (!abort_wr) begin
               rfe_ctrl_d   = tbl_word;
               settle_cnt_d = settle_q;
               dwell_cnt_d  = '0;
            end
         end
         ST_SETTLE: begin
            settle_cnt_d = settle_cnt_q - 16'd1;
         end
         ST_DWELL: begin
            if (hb_strobe) begin
               dwell_cnt_d = dwell_cnt_q + 16'd1;
            end
         end
         ST_NEXT: begin
            if (!abort_wr) begin
               if (step_index_q == last_q) begin
                  if (loop_q) begin
                     step_index_d = '0;
                  end else begin
                     sweep_done_d = 1'b1;
                  end
               end else begin
                  step_index_d = step_index_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // capture_en drops in the abort cycle itself, ahead of the registered state.
   assign capture_en = capture_en_q && !abort_wr;
   assign rfe_ctrl   = rfe_ctrl_q;
   assign busy       = (state_q != ST_IDLE);
   assign step_index = step_index_q;
   assign sweep_done = sweep_done_q;
   assign status     = pack_status(ovr_sticky_q, state_q, 8'(step_index_q), dwell_cnt_q[7:0]);

endmodule

// File: tb/tb_rfe_sweep_ctrl.sv
// Directed bench for rfe_sweep_ctrl: expected capture/done events queued by the
// stimulus, popped and compared by an independent output monitor.
module tb_rfe_sweep_ctrl;

   localparam logic [6:0] A_CTRL    = 7'd72;
   localparam logic [6:0] A_SETTLE  = 7'd73;
   localparam logic [6:0] A_SAMPLES = 7'd74;
   localparam logic [6:0] A_TABLE   = 7'd75;
   localparam logic [1:0] EV_SAMPLE = 2'd1;
   localparam logic [1:0] EV_DONE   = 2'd2;

   logic        clock, reset;
   logic        hb_strobe, rx_overrun;
   logic [5:0]  rfe_ctrl;
   logic        capture_en, busy, sweep_done;
   logic [2:0]  step_index;
   logic [31:0] status;

   logic        hb_auto, hb_man;
   int          hb_cnt;
   int          n_vec, n_err;
   logic [31:0] sb_q[$];

   rfe_sweep_ctrl_if sbus ();

   rfe_sweep_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .sbus       (sbus),
      .hb_strobe  (hb_strobe),
      .rx_overrun (rx_overrun),
      .rfe_ctrl   (rfe_ctrl),
      .capture_en (capture_en),
      .busy       (busy),
      .step_index (step_index),
      .sweep_done (sweep_done),
      .status     (status)
   );

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // hb_strobe: every third cycle in auto mode, otherwise follows hb_man.
   initial begin
      hb_strobe = 1'b0;
      hb_cnt    = 0;
      forever begin
         @(posedge clock);
         #2;
         hb_cnt++;
         hb_strobe = hb_auto ? (hb_cnt % 3 == 0) : hb_man;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   function automatic logic [31:0] ev(input logic [1:0] kind, input logic [2:0] step,
                                      input logic [5:0] word);
      return {21'b0, kind, step, word};
   endfunction

   function automatic logic [31:0] ctrl_w(input bit start, input bit abort, input bit loop,
                                          input logic [2:0] last, input bit clr);
      logic [31:0] w;
      w      = '0;
      w[0]   = start;
      w[1]   = abort;
      w[2]   = loop;
      w[6:4] = last;
      w[8]   = clr;
      return w;
   endfunction

   task automatic observe(input logic [31:0] got);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_unexpected: got %0h expected none", got);
      end else begin
         exp = sb_q.pop_front();
         check("sb_event", got, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (capture_en && hb_strobe) observe(ev(EV_SAMPLE, step_index, rfe_ctrl));
         if (sweep_done) observe(ev(EV_DONE, step_index, rfe_ctrl));
      end
   end

   task automatic bus_wr(input logic [6:0] a, input logic [31:0] d);
      @(posedge clock);
      #1;
      sbus.serial_addr   = a;
      sbus.serial_data   = d;
      sbus.serial_strobe = 1'b1;
      @(posedge clock);
      #1;
      sbus.serial_strobe = 1'b0;
   endtask

   task automatic tbl_wr(input logic [2:0] idx, input logic [5:0] word);
      bus_wr(A_TABLE, {13'b0, idx, 10'b0, word});
   endtask

   task automatic hb_pulse();
      @(posedge clock);
      #1 hb_man = 1'b1;
      @(posedge clock);
      #1 hb_man = 1'b0;
   endtask

   task automatic wait_cap(input string name);
      int g;
      g = 0;
      @(negedge clock);
      while (!capture_en && g < 300) begin
         g++;
         @(negedge clock);
      end
      if (!capture_en) timeout(name);
   endtask

   task automatic wait_idle(input string name);
      int g;
      g = 0;
      @(negedge clock);
      while (busy && g < 1000) begin
         g++;
         @(negedge clock);
      end
      if (busy) timeout(name);
   endtask

   initial begin
      int n, dead;
      bit saw_cap;
      logic [2:0] seq [5];
      logic [5:0] wrd [5];
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      rx_overrun = 1'b0;
      hb_auto = 1'b1;
      hb_man  = 1'b0;
      sbus.serial_addr   = '0;
      sbus.serial_data   = '0;
      sbus.serial_strobe = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      @(negedge clock);
      check("rst_rfe_ctrl", 32'(rfe_ctrl), 32'h0);
      check("rst_capture_en", 32'(capture_en), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_step_index", 32'(step_index), 32'h0);
      check("rst_sweep_done", 32'(sweep_done), 32'h0);
      check("rst_status", status, 32'h0);

      // Two-step sweep, settle 3, two samples per step.
      tbl_wr(3'd0, 6'h01);
      tbl_wr(3'd1, 6'h22);
      bus_wr(A_SETTLE, 32'd3);
      bus_wr(A_SAMPLES, 32'd2);
      sb_q.push_back(ev(EV_SAMPLE, 3'd0, 6'h01));
      sb_q.push_back(ev(EV_SAMPLE, 3'd0, 6'h01));
      sb_q.push_back(ev(EV_SAMPLE, 3'd1, 6'h22));
      sb_q.push_back(ev(EV_SAMPLE, 3'd1, 6'h22));
      sb_q.push_back(ev(EV_DONE, 3'd1, 6'h22));
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd1, 0));
      n = 0;
      @(negedge clock);
      while (rfe_ctrl != 6'h01 && n < 100) begin
         n++;
         @(negedge clock);
      end
      dead = 0;
      while (!capture_en && dead < 100) begin
         dead++;
         @(negedge clock);
      end
      check("t1_dead_cycles", 32'(dead), 32'd3);
      wait_idle("t1_idle");
      check("t1_rfe_final", 32'(rfe_ctrl), 32'h22);

      // No settle, no samples: APPLY/NEXT alternate, done 8 cycles after start.
      tbl_wr(3'd2, 6'h0C);
      tbl_wr(3'd3, 6'h33);
      bus_wr(A_SETTLE, 32'd0);
      bus_wr(A_SAMPLES, 32'd0);
      sb_q.push_back(ev(EV_DONE, 3'd3, 6'h33));
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd3, 0));
      @(negedge clock);
      check("t2_busy", 32'(busy), 32'h1);
      saw_cap = 1'b0;
      n = 0;
      while (!sweep_done && n < 50) begin
         @(negedge clock);
         n++;
         if (capture_en) saw_cap = 1'b1;
      end
      check("t2_done_latency", 32'(n), 32'd8);
      check("t2_no_capture", 32'(saw_cap), 32'h0);
      wait_idle("t2_idle");

      // Looping sweep over 0..2, then abort during the second pass.
      hb_auto = 1'b0;
      bus_wr(A_SETTLE, 32'd1);
      bus_wr(A_SAMPLES, 32'd1);
      seq = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
      wrd = '{6'h01, 6'h22, 6'h0C, 6'h01, 6'h22};
      bus_wr(A_CTRL, ctrl_w(1, 0, 1, 3'd2, 0));
      for (int i = 0; i < 5; i++) begin
         wait_cap("t3_wait_cap");
         check("t3_step_seq", 32'(step_index), 32'(seq[i]));
         if (i < 4) begin
            sb_q.push_back(ev(EV_SAMPLE, seq[i], wrd[i]));
            hb_pulse();
         end
      end
      @(posedge clock);
      #1;
      sbus.serial_addr   = A_CTRL;
      sbus.serial_data   = ctrl_w(0, 1, 1, 3'd2, 0);
      sbus.serial_strobe = 1'b1;
      @(negedge clock);
      check("t3_abort_cap_low", 32'(capture_en), 32'h0);
      check("t3_abort_busy_same", 32'(busy), 32'h1);
      @(posedge clock);
      #1 sbus.serial_strobe = 1'b0;
      @(negedge clock);
      check("t3_abort_busy_next", 32'(busy), 32'h0);
      check("t3_abort_rfe_held", 32'(rfe_ctrl), 32'h22);
      check("t3_abort_step_held", 32'(step_index), 32'h1);

      // Overrun sticky: set wins over a same-cycle clear, then explicit clear.
      sb_q.push_back(ev(EV_SAMPLE, 3'd0, 6'h01));
      sb_q.push_back(ev(EV_DONE, 3'd0, 6'h01));
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd0, 0));
      wait_cap("t4_wait_cap");
      @(posedge clock);
      #1;
      rx_overrun         = 1'b1;
      sbus.serial_addr   = A_CTRL;
      sbus.serial_data   = ctrl_w(0, 0, 0, 3'd0, 1);
      sbus.serial_strobe = 1'b1;
      @(posedge clock);
      #1;
      rx_overrun         = 1'b0;
      sbus.serial_strobe = 1'b0;
      @(negedge clock);
      check("t4_set_beats_clr", 32'(status[31]), 32'h1);
      hb_pulse();
      wait_idle("t4_idle");
      check("t4_status_idle", status, 32'h8000_0001);
      repeat (3) @(negedge clock);
      check("t4_sticky_persists", 32'(status[31]), 32'h1);
      bus_wr(A_CTRL, ctrl_w(0, 0, 0, 3'd0, 1));
      @(negedge clock);
      check("t4_status_cleared", status, 32'h0000_0001);
      @(posedge clock);
      #1 rx_overrun = 1'b1;
      repeat (2) @(posedge clock);
      #1 rx_overrun = 1'b0;
      @(negedge clock);
      check("t4_idle_ovr_ignored", 32'(status[31]), 32'h0);

      // start while busy is ignored; reset mid-settle clears everything.
      bus_wr(A_SETTLE, 32'd20);
      bus_wr(A_SAMPLES, 32'd1);
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd1, 0));
      repeat (3) @(negedge clock);
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd1, 0));
      @(negedge clock);
      check("t5_restart_state", 32'(status[18:16]), 32'd2);
      check("t5_restart_rfe", 32'(rfe_ctrl), 32'h01);
      @(posedge clock);
      #1 reset = 1'b1;
      #2;
      check("t5_rst_rfe", 32'(rfe_ctrl), 32'h0);
      check("t5_rst_busy", 32'(busy), 32'h0);
      check("t5_rst_status", status, 32'h0);
      check("t5_rst_outs", {29'b0, capture_en, sweep_done, |step_index}, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      tbl_wr(3'd0, 6'h05);
      tbl_wr(3'd1, 6'h2A);
      bus_wr(A_SETTLE, 32'd2);
      bus_wr(A_SAMPLES, 32'd1);
      sb_q.push_back(ev(EV_SAMPLE, 3'd0, 6'h05));
      sb_q.push_back(ev(EV_SAMPLE, 3'd1, 6'h2A));
      sb_q.push_back(ev(EV_DONE, 3'd1, 6'h2A));
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd1, 0));
      wait_cap("t5_wait_cap0");
      hb_pulse();
      wait_cap("t5_wait_cap1");
      hb_pulse();
      wait_idle("t5_idle");

      // Rewriting entry 1 while step 0 dwells takes effect at step 1.
      tbl_wr(3'd0, 6'h01);
      tbl_wr(3'd1, 6'h22);
      bus_wr(A_SETTLE, 32'd1);
      sb_q.push_back(ev(EV_SAMPLE, 3'd0, 6'h01));
      sb_q.push_back(ev(EV_SAMPLE, 3'd1, 6'h3F));
      sb_q.push_back(ev(EV_DONE, 3'd1, 6'h3F));
      bus_wr(A_CTRL, ctrl_w(1, 0, 0, 3'd1, 0));
      wait_cap("t6_wait_cap0");
      tbl_wr(3'd1, 6'h3F);
      hb_pulse();
      wait_cap("t6_wait_cap1");
      hb_pulse();
      wait_idle("t6_idle");

      repeat (5) @(negedge clock);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
